// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller for the five-stage F/D/E/M/W pipeline:
// per-stage stall/bubble generation, memory-timeout watchdog and perf counters.
module pipeline_ctrl #(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned MEM_TO      = 255,
  parameter logic [1:0]  WB_SEL_VALM = 2'd1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       dec_i_rs1,
  input  logic [4:0]       dec_i_rs2,
  input  logic             dec_i_is_system,
  input  logic             dec_i_need_jump,
  input  logic             regE_i_valid,
  input  logic             regM_i_valid,
  input  logic             regW_i_valid,
  input  logic [4:0]       regE_i_wb_rd,
  input  logic             regE_i_wb_reg_wen,
  input  logic [1:0]       regE_i_wb_valD_sel,
  input  logic             mem_i_req,
  input  logic             mem_i_ready,
  output logic             regF_o_stall,
  output logic             regD_o_stall,
  output logic             regE_o_stall,
  output logic             regM_o_stall,
  output logic             regD_o_bubble,
  output logic             regE_o_bubble,
  output logic             regW_o_bubble,
  output logic [1:0]       ctrl_o_state,
  output logic             ctrl_o_mem_timeout,
  output logic [CNT_W-1:0] perf_o_stall_cnt,
  output logic [CNT_W-1:0] perf_o_flush_cnt
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    DRAIN    = 2'd2,
    ERR      = 2'd3
  } state_t;

  localparam int unsigned WCNT_W   = (MEM_TO < 2) ? 1 : $clog2(MEM_TO + 1);
  // The cycle that entered MEM_WAIT and the current cycle are both wait
  // cycles, so the stored count trails the consecutive total by two.
  localparam int unsigned TO_LIM_I = (MEM_TO >= 2) ? MEM_TO - 2 : 0;
  localparam logic [WCNT_W-1:0] TO_LIM  = TO_LIM_I[WCNT_W-1:0];
  localparam logic [CNT_W-1:0]  CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t            state;
  state_t            state_nxt;
  logic [WCNT_W-1:0] wait_cnt;

  logic memwait;
  logic loaduse;
  logic pipebusy;
  logic sysdrain;

  function automatic logic [WCNT_W-1:0] sat_inc(input logic [WCNT_W-1:0] v);
    sat_inc = (&v) ? v : v + {{(WCNT_W-1){1'b0}}, 1'b1};
  endfunction

  assign memwait  = mem_i_req & ~mem_i_ready;
  assign loaduse  = regE_i_valid & regE_i_wb_reg_wen & (regE_i_wb_rd != 5'd0) &
                    (regE_i_wb_valD_sel == WB_SEL_VALM) &
                    ((regE_i_wb_rd == dec_i_rs1) | (regE_i_wb_rd == dec_i_rs2));
  assign pipebusy = regE_i_valid | regM_i_valid | regW_i_valid;
  assign sysdrain = dec_i_is_system & pipebusy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN: begin
        if (memwait) begin
          state_nxt = MEM_WAIT;
        end else if (sysdrain) begin
          state_nxt = DRAIN;
        end
      end
      MEM_WAIT: begin
        if (mem_i_ready) begin
          state_nxt = RUN;
        end else if (memwait && (wait_cnt >= TO_LIM)) begin
          state_nxt = ERR;
        end
      end
      DRAIN: begin
        if (memwait) begin
          state_nxt = MEM_WAIT;
        end else if (!pipebusy) begin
          state_nxt = RUN;
        end
      end
      default: state_nxt = ERR;
    endcase
  end

  // A jump only flushes when nothing holds decode; a held jump is simply
  // seen again once decode is released.
  always_comb begin
    regF_o_stall  = 1'b0;
    regD_o_stall  = 1'b0;
    regE_o_stall  = 1'b0;
    regM_o_stall  = 1'b0;
    regD_o_bubble = 1'b0;
    regE_o_bubble = 1'b0;
    regW_o_bubble = 1'b0;
    if ((state == ERR) || memwait) begin
      regF_o_stall  = 1'b1;
      regD_o_stall  = 1'b1;
      regE_o_stall  = 1'b1;
      regM_o_stall  = 1'b1;
      regW_o_bubble = 1'b1;
    end else if (loaduse || sysdrain) begin
      regF_o_stall  = 1'b1;
      regD_o_stall  = 1'b1;
      regE_o_bubble = 1'b1;
    end else if (dec_i_need_jump) begin
      regD_o_bubble = 1'b1;
    end
  end

  assign ctrl_o_state       = state;
  assign ctrl_o_mem_timeout = (state == ERR);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= '0;
    end else if (state != MEM_WAIT) begin
      wait_cnt <= '0;
    end else if (memwait) begin
      wait_cnt <= sat_inc(wait_cnt);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_o_stall_cnt <= '0;
      perf_o_flush_cnt <= '0;
    end else begin
      if (regF_o_stall) begin
        perf_o_stall_cnt <= perf_o_stall_cnt + CNT_ONE;
      end
      if (regD_o_bubble) begin
        perf_o_flush_cnt <= perf_o_flush_cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: scenario tasks with a scoreboard of
// expected stall/bubble vectors and next states.
module tb_pipeline_ctrl;

  localparam logic [1:0] VALM = 2'd1;
  localparam logic [1:0] VALE = 2'd0;
  localparam logic [6:0] NONE = 7'b0000_000;
  localparam logic [6:0] FRZ  = 7'b1111_001;
  localparam logic [6:0] HLD  = 7'b1100_010;
  localparam logic [6:0] JMP  = 7'b0000_100;

  typedef struct packed {
    logic       ev, mv, wv;
    logic [4:0] rd;
    logic       wen;
    logic [1:0] sel;
    logic [4:0] rs1, rs2;
    logic       sys, jmp, req, rdy;
  } stim_t;

  typedef struct {
    string      nm;
    logic [6:0] ctl;
    logic [1:0] st;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  dec_i_rs1, dec_i_rs2, regE_i_wb_rd;
  logic        dec_i_is_system, dec_i_need_jump;
  logic        regE_i_valid, regM_i_valid, regW_i_valid;
  logic        regE_i_wb_reg_wen, mem_i_req, mem_i_ready;
  logic [1:0]  regE_i_wb_valD_sel;
  logic        regF_o_stall, regD_o_stall, regE_o_stall, regM_o_stall;
  logic        regD_o_bubble, regE_o_bubble, regW_o_bubble;
  logic [1:0]  ctrl_o_state;
  logic        ctrl_o_mem_timeout;
  logic [31:0] perf_o_stall_cnt, perf_o_flush_cnt;
  logic [6:0]  ctl;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  assign ctl = {regF_o_stall, regD_o_stall, regE_o_stall, regM_o_stall,
                regD_o_bubble, regE_o_bubble, regW_o_bubble};

  pipeline_ctrl #(.CNT_W(32), .MEM_TO(4), .WB_SEL_VALM(VALM)) dut (
    .clk(clk), .rst(rst),
    .dec_i_rs1(dec_i_rs1), .dec_i_rs2(dec_i_rs2),
    .dec_i_is_system(dec_i_is_system), .dec_i_need_jump(dec_i_need_jump),
    .regE_i_valid(regE_i_valid), .regM_i_valid(regM_i_valid), .regW_i_valid(regW_i_valid),
    .regE_i_wb_rd(regE_i_wb_rd), .regE_i_wb_reg_wen(regE_i_wb_reg_wen),
    .regE_i_wb_valD_sel(regE_i_wb_valD_sel),
    .mem_i_req(mem_i_req), .mem_i_ready(mem_i_ready),
    .regF_o_stall(regF_o_stall), .regD_o_stall(regD_o_stall),
    .regE_o_stall(regE_o_stall), .regM_o_stall(regM_o_stall),
    .regD_o_bubble(regD_o_bubble), .regE_o_bubble(regE_o_bubble),
    .regW_o_bubble(regW_o_bubble),
    .ctrl_o_state(ctrl_o_state), .ctrl_o_mem_timeout(ctrl_o_mem_timeout),
    .perf_o_stall_cnt(perf_o_stall_cnt), .perf_o_flush_cnt(perf_o_flush_cnt)
  );

  function automatic stim_t mk(logic ev, logic mv, logic wv, logic [4:0] rd, logic wen,
                               logic [1:0] sel, logic [4:0] rs1, logic [4:0] rs2,
                               logic sys, logic jmp, logic req, logic rdy);
    mk = '{ev:ev, mv:mv, wv:wv, rd:rd, wen:wen, sel:sel, rs1:rs1, rs2:rs2,
           sys:sys, jmp:jmp, req:req, rdy:rdy};
  endfunction

  task automatic drive(input stim_t s);
    regE_i_valid       = s.ev;
    regM_i_valid       = s.mv;
    regW_i_valid       = s.wv;
    regE_i_wb_rd       = s.rd;
    regE_i_wb_reg_wen  = s.wen;
    regE_i_wb_valD_sel = s.sel;
    dec_i_rs1          = s.rs1;
    dec_i_rs2          = s.rs2;
    dec_i_is_system    = s.sys;
    dec_i_need_jump    = s.jmp;
    mem_i_req          = s.req;
    mem_i_ready        = s.rdy;
  endtask

  task automatic test_reset();
    drive(mk(0,0,0,0,0,VALE,0,0,0,0,0,0));
    #3;
    checks++;
    if (ctrl_o_state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d expected 0", ctrl_o_state); end
    checks++;
    if (ctrl_o_mem_timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout got %b expected 0", ctrl_o_mem_timeout); end
    checks++;
    if (perf_o_stall_cnt !== 32'd0 || perf_o_flush_cnt !== 32'd0) begin
      errors++; $display("FAIL reset_counters got %0d/%0d expected 0/0", perf_o_stall_cnt, perf_o_flush_cnt);
    end
    checks++;
    if (ctl !== NONE) begin errors++; $display("FAIL reset_ctl got %b expected %b", ctl, NONE); end
    drive(mk(0,0,0,0,0,VALE,0,0,0,1,0,0));
    #1;
    checks++;
    if (ctl !== JMP) begin errors++; $display("FAIL reset_jump_ctl got %b expected %b", ctl, JMP); end
    drive(mk(0,0,0,0,0,VALE,0,0,0,0,0,0));
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_loaduse();
    stim_t s[7];
    logic [6:0] c[7];
    logic [1:0] q[7];
    logic [31:0] bs, bf;
    exp_t e;
    s = '{mk(1,0,0,5,1,VALM,5,0,0,0,0,0), mk(0,1,0,5,1,VALM,5,0,0,0,0,0),
          mk(1,0,0,0,1,VALM,0,0,0,0,0,0), mk(1,0,0,7,1,VALM,3,7,0,0,0,0),
          mk(1,0,0,5,1,VALE,5,0,0,0,0,0), mk(1,0,0,5,0,VALM,5,0,0,0,0,0),
          mk(0,0,0,5,1,VALM,5,0,0,0,0,0)};
    c = '{HLD, NONE, NONE, HLD, NONE, NONE, NONE};
    q = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
    bs = perf_o_stall_cnt; bf = perf_o_flush_cnt;
    for (int i = 0; i < 7; i++) begin
      drive(s[i]);
      sb.push_back('{$sformatf("loaduse%0d", i), c[i], q[i]});
      #2;
      e = sb.pop_front();
      checks++;
      if (ctl !== e.ctl) begin errors++; $display("FAIL %s_ctl got %b expected %b", e.nm, ctl, e.ctl); end
      @(posedge clk); #1;
      checks++;
      if (ctrl_o_state !== e.st) begin errors++; $display("FAIL %s_state got %0d expected %0d", e.nm, ctrl_o_state, e.st); end
      @(negedge clk);
    end
    checks++;
    if (perf_o_stall_cnt - bs !== 32'd2) begin errors++; $display("FAIL loaduse_stall_cnt got %0d expected 2", perf_o_stall_cnt - bs); end
    checks++;
    if (perf_o_flush_cnt - bf !== 32'd0) begin errors++; $display("FAIL loaduse_flush_cnt got %0d expected 0", perf_o_flush_cnt - bf); end
  endtask

  task automatic test_memwait();
    stim_t s[5];
    logic [6:0] c[5];
    logic [1:0] q[5];
    logic [31:0] bs;
    exp_t e;
    s = '{mk(0,1,0,0,0,VALE,0,0,0,0,1,0), mk(0,1,0,0,0,VALE,0,0,0,0,1,0),
          mk(0,1,0,0,0,VALE,0,0,0,0,1,0), mk(0,1,0,0,0,VALE,0,0,0,0,1,1),
          mk(0,0,0,0,0,VALE,0,0,0,0,0,0)};
    c = '{FRZ, FRZ, FRZ, NONE, NONE};
    q = '{2'd1, 2'd1, 2'd1, 2'd0, 2'd0};
    bs = perf_o_stall_cnt;
    for (int i = 0; i < 5; i++) begin
      drive(s[i]);
      sb.push_back('{$sformatf("memwait%0d", i), c[i], q[i]});
      #2;
      e = sb.pop_front();
      checks++;
      if (ctl !== e.ctl) begin errors++; $display("FAIL %s_ctl got %b expected %b", e.nm, ctl, e.ctl); end
      @(posedge clk); #1;
      checks++;
      if (ctrl_o_state !== e.st) begin errors++; $display("FAIL %s_state got %0d expected %0d", e.nm, ctrl_o_state, e.st); end
      @(negedge clk);
    end
    checks++;
    if (perf_o_stall_cnt - bs !== 32'd3) begin errors++; $display("FAIL memwait_stall_cnt got %0d expected 3", perf_o_stall_cnt - bs); end
    checks++;
    if (ctrl_o_mem_timeout !== 1'b0) begin errors++; $display("FAIL memwait_timeout got %b expected 0", ctrl_o_mem_timeout); end
  endtask

  task automatic test_drain();
    stim_t s[5];
    logic [6:0] c[5];
    logic [1:0] q[5];
    logic [31:0] bs, bf;
    exp_t e;
    s = '{mk(1,1,1,0,0,VALE,1,2,1,1,0,0), mk(0,1,1,0,0,VALE,1,2,1,1,0,0),
          mk(0,0,1,0,0,VALE,1,2,1,1,0,0), mk(0,0,0,0,0,VALE,1,2,1,1,0,0),
          mk(0,0,0,0,0,VALE,0,0,0,0,0,0)};
    c = '{HLD, HLD, HLD, JMP, NONE};
    q = '{2'd2, 2'd2, 2'd2, 2'd0, 2'd0};
    bs = perf_o_stall_cnt; bf = perf_o_flush_cnt;
    for (int i = 0; i < 5; i++) begin
      drive(s[i]);
      sb.push_back('{$sformatf("drain%0d", i), c[i], q[i]});
      #2;
      e = sb.pop_front();
      checks++;
      if (ctl !== e.ctl) begin errors++; $display("FAIL %s_ctl got %b expected %b", e.nm, ctl, e.ctl); end
      @(posedge clk); #1;
      checks++;
      if (ctrl_o_state !== e.st) begin errors++; $display("FAIL %s_state got %0d expected %0d", e.nm, ctrl_o_state, e.st); end
      @(negedge clk);
    end
    checks++;
    if (perf_o_stall_cnt - bs !== 32'd3) begin errors++; $display("FAIL drain_stall_cnt got %0d expected 3", perf_o_stall_cnt - bs); end
    checks++;
    if (perf_o_flush_cnt - bf !== 32'd1) begin errors++; $display("FAIL drain_flush_cnt got %0d expected 1", perf_o_flush_cnt - bf); end
  endtask

  task automatic test_jump();
    stim_t s[5];
    logic [6:0] c[5];
    logic [1:0] q[5];
    logic [31:0] bs, bf;
    exp_t e;
    s = '{mk(0,0,0,0,0,VALE,0,0,0,1,0,0), mk(0,0,0,0,0,VALE,0,0,0,0,0,0),
          mk(1,0,0,5,1,VALM,5,0,0,1,0,0), mk(0,1,0,5,1,VALM,5,0,0,1,0,0),
          mk(0,0,0,0,0,VALE,0,0,0,0,0,0)};
    c = '{JMP, NONE, HLD, JMP, NONE};
    q = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
    bs = perf_o_stall_cnt; bf = perf_o_flush_cnt;
    for (int i = 0; i < 5; i++) begin
      drive(s[i]);
      sb.push_back('{$sformatf("jump%0d", i), c[i], q[i]});
      #2;
      e = sb.pop_front();
      checks++;
      if (ctl !== e.ctl) begin errors++; $display("FAIL %s_ctl got %b expected %b", e.nm, ctl, e.ctl); end
      @(posedge clk); #1;
      checks++;
      if (ctrl_o_state !== e.st) begin errors++; $display("FAIL %s_state got %0d expected %0d", e.nm, ctrl_o_state, e.st); end
      @(negedge clk);
    end
    checks++;
    if (perf_o_stall_cnt - bs !== 32'd1) begin errors++; $display("FAIL jump_stall_cnt got %0d expected 1", perf_o_stall_cnt - bs); end
    checks++;
    if (perf_o_flush_cnt - bf !== 32'd2) begin errors++; $display("FAIL jump_flush_cnt got %0d expected 2", perf_o_flush_cnt - bf); end
  endtask

  task automatic test_priority();
    stim_t s[5];
    logic [6:0] c[5];
    logic [1:0] q[5];
    logic [31:0] bs, bf;
    exp_t e;
    s = '{mk(1,1,0,5,1,VALM,5,0,0,1,1,0), mk(1,1,0,5,1,VALM,5,0,0,1,1,0),
          mk(1,1,0,5,1,VALM,5,0,0,1,1,1), mk(0,1,0,5,1,VALM,5,0,0,1,1,1),
          mk(0,0,0,0,0,VALE,0,0,0,0,0,0)};
    c = '{FRZ, FRZ, HLD, JMP, NONE};
    q = '{2'd1, 2'd1, 2'd0, 2'd0, 2'd0};
    bs = perf_o_stall_cnt; bf = perf_o_flush_cnt;
    for (int i = 0; i < 5; i++) begin
      drive(s[i]);
      sb.push_back('{$sformatf("priority%0d", i), c[i], q[i]});
      #2;
      e = sb.pop_front();
      checks++;
      if (ctl !== e.ctl) begin errors++; $display("FAIL %s_ctl got %b expected %b", e.nm, ctl, e.ctl); end
      @(posedge clk); #1;
      checks++;
      if (ctrl_o_state !== e.st) begin errors++; $display("FAIL %s_state got %0d expected %0d", e.nm, ctrl_o_state, e.st); end
      @(negedge clk);
    end
    checks++;
    if (perf_o_stall_cnt - bs !== 32'd3) begin errors++; $display("FAIL priority_stall_cnt got %0d expected 3", perf_o_stall_cnt - bs); end
    checks++;
    if (perf_o_flush_cnt - bf !== 32'd1) begin errors++; $display("FAIL priority_flush_cnt got %0d expected 1", perf_o_flush_cnt - bf); end
  endtask

  task automatic test_timeout();
    stim_t s[6];
    logic [6:0] c[6];
    logic [1:0] q[6];
    exp_t e;
    s = '{mk(0,1,0,0,0,VALE,0,0,0,0,1,0), mk(0,1,0,0,0,VALE,0,0,0,0,1,0),
          mk(0,1,0,0,0,VALE,0,0,0,0,1,0), mk(0,1,0,0,0,VALE,0,0,0,0,1,0),
          mk(0,0,0,0,0,VALE,0,0,0,1,0,0), mk(0,1,0,0,0,VALE,0,0,0,0,1,1)};
    c = '{FRZ, FRZ, FRZ, FRZ, FRZ, FRZ};
    q = '{2'd1, 2'd1, 2'd1, 2'd3, 2'd3, 2'd3};
    for (int i = 0; i < 6; i++) begin
      drive(s[i]);
      sb.push_back('{$sformatf("timeout%0d", i), c[i], q[i]});
      #2;
      e = sb.pop_front();
      checks++;
      if (ctl !== e.ctl) begin errors++; $display("FAIL %s_ctl got %b expected %b", e.nm, ctl, e.ctl); end
      @(posedge clk); #1;
      checks++;
      if (ctrl_o_state !== e.st) begin errors++; $display("FAIL %s_state got %0d expected %0d", e.nm, ctrl_o_state, e.st); end
      @(negedge clk);
    end
    checks++;
    if (ctrl_o_mem_timeout !== 1'b1) begin errors++; $display("FAIL timeout_flag got %b expected 1", ctrl_o_mem_timeout); end
    drive(mk(0,0,0,0,0,VALE,0,0,0,0,0,0));
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (ctrl_o_state !== 2'd0) begin errors++; $display("FAIL timeout_rst_state got %0d expected 0", ctrl_o_state); end
    checks++;
    if (ctrl_o_mem_timeout !== 1'b0) begin errors++; $display("FAIL timeout_rst_flag got %b expected 0", ctrl_o_mem_timeout); end
    checks++;
    if (perf_o_stall_cnt !== 32'd0 || perf_o_flush_cnt !== 32'd0) begin
      errors++; $display("FAIL timeout_rst_counters got %0d/%0d expected 0/0", perf_o_stall_cnt, perf_o_flush_cnt);
    end
    checks++;
    if (ctl !== NONE) begin errors++; $display("FAIL timeout_rst_ctl got %b expected %b", ctl, NONE); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    test_reset();
    test_loaduse();
    test_memwait();
    test_drain();
    test_jump();
    test_priority();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
